serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Multi-cycle unsigned subtractor with borrow-in/borrow-out; the arithmetic inverse of the team's single-cycle carry adder.
- Computes A - B - bin over WIDTH/DIGIT clock cycles, DIGIT bits per cycle, LSB first.
- Uses a start/busy/done handshake so datapath blocks can share one small subtract unit instead of a full-width combinational borrow chain.

Parameters:
- WIDTH, 32, operand and result width in bits.
- DIGIT, 4, bits processed per cycle. WIDTH must be an integer multiple of DIGIT. N = WIDTH/DIGIT is the digit count.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when idle
- A  input  WIDTH  minuend; sampled with start
- B  input  WIDTH  subtrahend; sampled with start
- bin  input  1  borrow-in; sampled with start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when diff/bout/ovf become valid
- diff  output  WIDTH  (A - B - bin) mod 2^WIDTH
- bout  output  1  borrow-out: 1 iff A < B + bin, unsigned
- ovf  output  1  signed overflow of A - B - bin, two's complement

Behaviour:
- Reset (async, any time, including mid-operation):
  - State goes to IDLE.
  - busy=0, done=0, diff=0, bout=0, ovf=0.
  - Digit counter and internal shift registers are cleared; the aborted operation produces no done pulse.
- States: IDLE, RUN.
- IDLE:
  - busy=0.
  - If start=1 at a rising edge: latch A, B and bin into internal operand and borrow registers, clear the counter, and go to RUN.
  - diff/bout/ovf keep their previous values until the new result completes.
- RUN:
  - busy=1.
  - Each edge computes {borrow, digit} = a[DIGIT-1:0] - b[DIGIT-1:0] - borrow.
  - The digit is shifted into the result register from the MSB side; the operands shift right by DIGIT; the counter increments.
- Completion, on the edge that processes digit N-1:
  - State returns to IDLE.
  - diff is loaded with the assembled result, bout with the final borrow.
  - ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]), using the latched A and B.
  - done=1 for exactly the next cycle.
- Latency:
  - If start is sampled at edge t0, busy is high from t0 to t0+N, and done is high between edges t0+N and t0+N+1.
  - With defaults N=8.
- Outputs diff/bout/ovf are stable and held from the done pulse until the completion of the next operation.
- start while busy=1 is ignored and has no queueing effect.
- A, B and bin may change freely after the start edge, since only latched copies are used.
- start high during the done cycle (state is IDLE) is accepted. Back-to-back throughput is one result per N+1 cycles... more precisely, the next operation begins at that edge.
- start held high continuously restarts an operation at every return to IDLE.
- bin=1 with A=B yields diff = all-ones, bout=1.
- WIDTH=DIGIT (N=1) must work: done follows start by one edge.

Test Plan:
1. A=0, B=11, bin=1, start pulse -> busy for 8 cycles, then done pulse; diff=0xFFFFFFF4, bout=1, ovf=0.
2. A=1, B=0xFFFFFFFF, bin=0 -> diff=0x00000002, bout=1, ovf=0. Then A=0xCCCCAAAA, B=1, bin=0 -> diff=0xCCCCAAA9, bout=0, ovf=0.
3. A=0x80000000, B=1, bin=0 -> diff=0x7FFFFFFF, bout=0, ovf=1. Then A=0x7FFFFFFF, B=0xFFFFFFFF -> diff=0x80000000, bout=1, ovf=1.
4. Start an operation with A=5, B=3; pulse start with different operands at cycles 2 and 5 while busy; change A/B mid-run -> single done after 8 cycles, diff=2, no extra done.
5. Assert rst asynchronously between clock edges at cycle 4 of an operation -> outputs zero immediately, busy=0, no done. A later start with A=B=0x12345678, bin=0 -> diff=0, bout=0.
6. Hold start high with A=10, B=4 -> done pulses every 9 cycles with diff=6. Repeat the run with WIDTH=8, DIGIT=8 and A=0x00, B=0x01 -> done one edge after start, diff=0xFF, bout=1.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Multi-cycle unsigned subtractor: diff = (A - B - bin) mod 2^WIDTH,
//   computed DIGIT bits per clock, LSB first, over N = WIDTH/DIGIT cycles.
//   Also reports the unsigned borrow-out and the two's-complement overflow.
//
// Ports
//   clk    rising-edge clock
//   rst    asynchronous, active-high reset
//   start  operation request, sampled only while idle
//   A, B   minuend / subtrahend, latched with start
//   bin    borrow-in, latched with start
//   busy   high while an operation is in progress
//   done   one-cycle pulse when diff/bout/ovf are updated
//   diff   result, held until the next operation completes
//   bout   borrow-out: 1 iff A < B + bin (unsigned)
//   ovf    signed overflow of A - B - bin
module serial_subtractor #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             a_msb;
    logic             b_msb;

    logic [DIGIT:0]   step;
    logic [DIGIT-1:0] dig;
    logic             brw_nxt;
    logic [WIDTH-1:0] res_nxt;
    logic             last;

    assign busy = (state == S_RUN);

    always_comb begin
        // One extra bit on top catches the borrow: the difference is
        // negative exactly when that bit comes out set.
        step    = {1'b0, a_sr[DIGIT-1:0]} - {1'b0, b_sr[DIGIT-1:0]}
                  - {{DIGIT{1'b0}}, borrow};
        dig     = step[DIGIT-1:0];
        brw_nxt = step[DIGIT];
        // New digit enters at the MSB end; after N shifts digit 0 sits at
        // the LSB. Written as shifts so WIDTH == DIGIT needs no special case.
        res_nxt = (res_sr >> DIGIT) | (WIDTH'(dig) << (WIDTH - DIGIT));
        last    = (cnt == CW'(N - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sr   <= A;
                        b_sr   <= B;
                        borrow <= bin;
                        a_msb  <= A[WIDTH-1];
                        b_msb  <= B[WIDTH-1];
                        cnt    <= '0;
                        res_sr <= '0;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_sr   <= a_sr >> DIGIT;
                    b_sr   <= b_sr >> DIGIT;
                    borrow <= brw_nxt;
                    res_sr <= res_nxt;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        state <= S_IDLE;
                        diff  <= res_nxt;
                        bout  <= brw_nxt;
                        // Overflow only possible when operand signs differ;
                        // then it shows as a result sign differing from A.
                        ovf   <= (a_msb != b_msb) && (res_nxt[WIDTH-1] != a_msb);
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Scoreboard bench for serial_subtractor: a 32-bit/4-bit-digit instance
//   and an 8-bit/8-bit-digit (single digit) instance. Expected results are
//   queued at issue time from an arithmetic model and popped by per-DUT
//   monitors whenever done is seen.
module tb_serial_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic        st32, bin32, busy32, done32, bout32, ovf32;
    logic [31:0] a32, b32, diff32;

    logic        st8, bin8, busy8, done8, bout8, ovf8;
    logic [7:0]  a8, b8, diff8;

    serial_subtractor #(.WIDTH(32), .DIGIT(4)) dut32 (
        .clk(clk), .rst(rst), .start(st32), .A(a32), .B(b32), .bin(bin32),
        .busy(busy32), .done(done32), .diff(diff32), .bout(bout32), .ovf(ovf32)
    );

    serial_subtractor #(.WIDTH(8), .DIGIT(8)) dut8 (
        .clk(clk), .rst(rst), .start(st8), .A(a8), .B(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
    );

    typedef struct packed {
        logic [31:0] d;
        logic        bo;
        logic        ov;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];
    exp_t e32, e8;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting for done (t=%0t)", name, $time);
    endtask

    // Reference: plain integer arithmetic on w-bit operands.
    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic bi);
        longint m, ua, ub, r, sa, sb, sr;
        exp_t   x;
        m  = longint'(1) << w;
        ua = longint'(a) & (m - 1);
        ub = longint'(b) & (m - 1);
        r  = ua - ub - longint'(bi);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        sr = sa - sb - longint'(bi);
        x.d  = 32'(r & (m - 1));
        x.bo = (r < 0);
        x.ov = (sr < -(m / 2)) || (sr >= m / 2);
        return x;
    endfunction

    // Monitors: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done32 === 1'b1) begin
            if (q32.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_done32: done seen with empty queue (t=%0t)", $time);
            end else begin
                e32 = q32.pop_front();
                check("diff32", 64'(diff32), 64'(e32.d));
                check("bout32", 64'(bout32), 64'(e32.bo));
                check("ovf32",  64'(ovf32),  64'(e32.ov));
            end
        end
    end

    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            if (q8.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_done8: done seen with empty queue (t=%0t)", $time);
            end else begin
                e8 = q8.pop_front();
                check("diff8", 64'(diff8), 64'(e8.d[7:0]));
                check("bout8", 64'(bout8), 64'(e8.bo));
                check("ovf8",  64'(ovf8),  64'(e8.ov));
            end
        end
    end

    task automatic set_start(input int w, input logic s);
        if (w == 8) st8 = s;
        else        st32 = s;
    endtask

    // Drive operands with start=1 and queue the expected result.
    task automatic issue(input int w, input logic [31:0] a, input logic [31:0] b, input logic bi);
        if (w == 8) begin
            a8 = a[7:0]; b8 = b[7:0]; bin8 = bi; st8 = 1'b1;
            q8.push_back(model(8, a, b, bi));
        end else begin
            a32 = a; b32 = b; bin32 = bi; st32 = 1'b1;
            q32.push_back(model(32, a, b, bi));
        end
    endtask

    // Single pulsed operation with a cycle-by-cycle busy/done trace.
    task automatic op(input int w, input logic [31:0] a, input logic [31:0] b, input logic bi);
        int n;
        n = (w == 8) ? 1 : 8;
        issue(w, a, b, bi);
        @(posedge clk); #1;
        set_start(w, 1'b0);
        for (int k = 0; k <= n; k++) begin
            check("busy_trace", 64'((w == 8) ? busy8 : busy32), 64'(k < n));
            check("done_trace", 64'((w == 8) ? done8 : done32), 64'(k == n));
            if (k < n) begin
                @(posedge clk); #1;
            end
        end
    endtask

    // Counts edges (sampling 1ns after each) until done is seen.
    task automatic wait_done(input int w, output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!((w == 8) ? done8 : done32) && lat < 60);
        if (!((w == 8) ? done8 : done32)) timeout_fail("wait_done");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;

        rst = 1'b1;
        st32 = 1'b0; a32 = '0; b32 = '0; bin32 = 1'b0;
        st8  = 1'b0; a8  = '0; b8  = '0; bin8  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy32", 64'(busy32), 64'(0));
        check("rst_done32", 64'(done32), 64'(0));
        check("rst_diff32", 64'(diff32), 64'(0));
        check("rst_bout32", 64'(bout32), 64'(0));
        check("rst_ovf32",  64'(ovf32),  64'(0));
        check("rst_busy8",  64'(busy8),  64'(0));
        check("rst_diff8",  64'(diff8),  64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors (back-to-back: each issues during the prior done cycle)
        op(32, 32'h0000_0000, 32'h0000_000B, 1'b1);
        op(32, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
        op(32, 32'hCCCC_AAAA, 32'h0000_0001, 1'b0);
        op(32, 32'h8000_0000, 32'h0000_0001, 1'b0);
        op(32, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        op(32, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 1'b1);
        op(32, 32'h0000_0000, 32'h0000_0000, 1'b0);

        // Randomized
        for (int i = 0; i < 16; i++)
            op(32, $urandom, $urandom, 1'($urandom_range(0, 1)));

        // start pulses while busy are ignored; inputs change mid-run
        issue(32, 32'd5, 32'd3, 1'b0);
        @(posedge clk); #1;
        st32 = 1'b0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(posedge clk); #1;
            a32 = $urandom; b32 = $urandom; bin32 = 1'($urandom_range(0, 1));
            st32 = (cyc == 2 || cyc == 5);
            if (cyc == 8) check("t4_done_at_8", 64'(done32), 64'(1));
        end
        st32 = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("t4_queue_drained", 64'(q32.size()), 64'(0));

        // Asynchronous reset mid-operation
        issue(32, 32'hFFFF_0000, 32'h0000_0001, 1'b0);
        @(posedge clk); #1;
        st32 = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_busy", 64'(busy32), 64'(0));
        check("arst_done", 64'(done32), 64'(0));
        check("arst_diff", 64'(diff32), 64'(0));
        check("arst_bout", 64'(bout32), 64'(0));
        check("arst_ovf",  64'(ovf32),  64'(0));
        q32.delete();
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        op(32, 32'h1234_5678, 32'h1234_5678, 1'b0);

        // start held high: one result every N+1 cycles
        issue(32, 32'd10, 32'd4, 1'b0);
        q32.push_back(model(32, 32'd10, 32'd4, 1'b0));
        q32.push_back(model(32, 32'd10, 32'd4, 1'b0));
        wait_done(32, lat);
        check("held32_first", 64'(lat), 64'(9));
        wait_done(32, lat);
        check("held32_period", 64'(lat), 64'(9));
        @(posedge clk); #1;
        st32 = 1'b0;
        wait_done(32, lat);
        check("held32_period2", 64'(lat + 1), 64'(9));
        repeat (12) @(posedge clk);
        #1;
        check("held32_drained", 64'(q32.size()), 64'(0));

        // Single-digit instance
        op(8, 32'h00, 32'h01, 1'b0);
        op(8, 32'h80, 32'h01, 1'b0);
        op(8, 32'h7F, 32'hFF, 1'b1);
        for (int i = 0; i < 8; i++)
            op(8, $urandom, $urandom, 1'($urandom_range(0, 1)));
        @(posedge clk); #1;

        issue(8, 32'h00, 32'h01, 1'b0);
        q8.push_back(model(8, 32'h00, 32'h01, 1'b0));
        q8.push_back(model(8, 32'h00, 32'h01, 1'b0));
        wait_done(8, lat);
        check("held8_first", 64'(lat), 64'(2));
        wait_done(8, lat);
        check("held8_period", 64'(lat), 64'(2));
        @(posedge clk); #1;
        st8 = 1'b0;
        wait_done(8, lat);
        check("held8_period2", 64'(lat + 1), 64'(2));
        repeat (6) @(posedge clk);
        #1;
        check("held8_drained", 64'(q8.size()), 64'(0));
        check("final_q32_empty", 64'(q32.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
